accum_scheduler: RTL
====================

// Module: accum_scheduler
// PURPOSE
// - Front-end controller for the 2-cycle accumulating RAM (read at issue, write-back of read+summand 2 cycles later).
// - Serialises upstream accumulate requests with ready/valid flow control.
// - Stalls same-address requests that would read stale data.
// - On command, sweeps every address in order and streams the accumulated totals out.
// PARAMETERS
// - WIDTH     32   accumulator/summand width, bits
// - DEPTH     1024 number of bins; AW = $clog2(DEPTH)
// - PIPE_LAT  2    cycles from RAM issue to write-back; also the hazard window
// PORTS
// - clk_in              in   1      system clock
// - rst_in              in   1      synchronous, active-high reset
// - req_addr_in         in   AW     bin to accumulate into
// - req_summand_in      in   WIDTH  value to add
// - req_valid_in        in   1      request present
// - req_ready_out       out  1      request accepted this cycle when valid&ready
// - dump_start_in       in   1      pulse: begin full-table readout
// - dump_busy_out       out  1      high from accepted dump_start until last dump word is out
// - ram_addr_out        out  AW     to RAM addr_in
// - ram_summand_out     out  WIDTH  to RAM summand_in
// - ram_valid_out       out  1      to RAM request_valid_in
// - ram_sum_in          in   WIDTH  from RAM sum_out
// - ram_addr_ret_in     in   AW     from RAM addr_out
// - ram_result_valid_in in   1      from RAM result_valid_out
// - dump_data_out       out  WIDTH  bin total during dump
// - dump_addr_out       out  AW     bin index of dump_data_out
// - dump_valid_out      out  1      dump word valid, one cycle per bin
// - dump_last_out       out  1      with dump_valid_out for bin DEPTH-1
// - stall_count_out     out  32     saturating count of hazard-stall cycles
// BEHAVIOUR
// - Reset: all outputs 0 except req_ready_out = 0 for the reset cycle, then 1.
// - Reset also clears the in-flight tracker, the FSM (-> ACCUM) and stall_count.
// - RAM contents are NOT cleared by reset.
// - Issue path is combinational from accept:
//   - ram_valid_out = req_valid_in & req_ready_out in ACCUM.
//   - ram_addr_out and ram_summand_out pass through the request fields.
// - In-flight tracker: PIPE_LAT-deep shift of {valid, addr, is_dump}; every cycle it shifts in the current issue.
// - Hazard: in ACCUM, req_ready_out = 0 when req_valid_in and req_addr_in matches any valid tracker entry.
//   - Example: issue at t to addr A -> A is blocked at t+1 and t+2; A is accepted at t+3.
//   - Each cycle with valid & hazard increments stall_count_out, saturating at 2^32-1.
// - FSM states: ACCUM, DRAIN, DUMP_ISSUE, DUMP_WAIT.
//   - ACCUM -> DRAIN on dump_start_in.
//     - req_ready_out = 0 from that same cycle; a request presented that cycle is not accepted.
//   - DRAIN: no issue; -> DUMP_ISSUE when the tracker holds no valid entries.
//   - DUMP_ISSUE: issues addr 0..DEPTH-1, one per cycle, with summand 0 and is_dump = 1.
//     - Consecutive distinct addresses, so no hazards.
//     - After issuing DEPTH-1 -> DUMP_WAIT.
//   - DUMP_WAIT: -> ACCUM on the cycle dump_last_out fires; req_ready_out returns the next cycle.
// - Dump output: when ram_result_valid_in and the returning tracker tail is_dump:
//   - dump_valid_out = 1, dump_data_out = ram_sum_in, dump_addr_out = ram_addr_ret_in.
//   - Latency is PIPE_LAT from issue; one word per cycle, no backpressure.
// - Dump is read-only: summand 0 rewrites the same value.
// - dump_start_in outside ACCUM is ignored.
// - dump_busy_out is high in DRAIN, DUMP_ISSUE and DUMP_WAIT.
// - Arithmetic wraps modulo 2^WIDTH inside the RAM; this block does no arithmetic.
// - Mid-operation rst_in abandons the dump.
//   - Any RAM write-back already in flight still completes inside the RAM.
//   - dump_valid_out stays 0 after reset regardless of returning results.
// STRUCTURE
// - Package accum_sched_pkg holds:
//   - typedef enum logic [1:0] sched_state_t {ACCUM, DRAIN, DUMP_ISSUE, DUMP_WAIT}.
//   - localparam PIPE_LAT_DEFAULT = 2.
//   - typedef struct inflight_t {valid, addr, is_dump}, parameterised by AW via the module.
// - Sub-module inflight_tracker (PIPE_LAT-deep shift register):
//   - Per-entry address compare -> hazard_out, empty_out.
//   - Tail entry -> tail_is_dump_out.
// - The top-level owns the FSM, the address sweep counter and the stall counter.
// TESTING
// - All benches use DEPTH=16, PIPE_LAT=2 and a behavioural 2-cycle accumulating RAM model.
// - Back-to-back reqs to addrs 1,2,3, summand 5 each -> all accepted with no stall; each bin reads 5.
// - Reqs addr 4 (+1) then addr 4 (+2) on consecutive cycles:
//   - second req sees ready = 0 for 2 cycles and is accepted at t+3;
//   - bin 4 = 3; stall_count = 2.
// - Reqs A=7 (+1), B=8 (+1), A=7 (+1) back-to-back:
//   - third req stalls 1 cycle; bin 7 = 2; stall_count = 1.
// - Preload bin i = i, then pulse dump_start:
//   - 16 dump words, addr 0..15, data 0..15, on consecutive cycles;
//   - dump_last with addr 15; RAM unchanged afterwards.
// - dump_start in the same cycle as a valid req, with 2 ops in flight:
//   - req not accepted; first dump issue only after the tracker empties;
//   - dump_busy high throughout; ready returns after dump_last.
// - rst_in asserted mid-dump (after bin 6):
//   - no further dump_valid; FSM in ACCUM; stall_count = 0;
//   - a subsequent req to bin 3 is accepted and accumulates onto the old value.

Source files
------------

// File: rtl/accum_scheduler_pkg.sv
// Shared types and defaults for the accumulating-RAM front-end scheduler.
package accum_sched_pkg;

    typedef enum logic [1:0] {
        ACCUM      = 2'd0,
        DRAIN      = 2'd1,
        DUMP_ISSUE = 2'd2,
        DUMP_WAIT  = 2'd3
    } sched_state_t;

    localparam int PIPE_LAT_DEFAULT = 2;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/accum_scheduler_inflight_tracker.sv
// Shift register of the last PIPE_LAT RAM issues; flags read-after-write hazards
// and identifies whether the result now returning from the RAM belongs to a dump.
module inflight_tracker
    import accum_sched_pkg::*;
#(
    parameter int AW       = 10,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push_valid_in,
    input  logic [AW-1:0] push_addr_in,
    input  logic          push_is_dump_in,
    input  logic [AW-1:0] cmp_addr_in,
    output logic          hazard_out,
    output logic          empty_out,
    output logic          tail_is_dump_out
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic          is_dump;
    } inflight_t;

    inflight_t r_entries [PIPE_LAT];

    // Shift the current issue in every cycle; the tail lines up with the RAM result.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_entries[0] <= '{valid: push_valid_in, addr: push_addr_in,
                              is_dump: push_is_dump_in & push_valid_in};
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_entries[i] <= r_entries[i-1];
            end
        end
    end

    // Per-entry address compare and occupancy reduction.
    always_comb begin
        hazard_out = 1'b0;
        empty_out  = 1'b1;
        for (int i = 0; i < PIPE_LAT; i++) begin
            hazard_out = hazard_out | (r_entries[i].valid & (r_entries[i].addr == cmp_addr_in));
            empty_out  = empty_out & ~r_entries[i].valid;
        end
        tail_is_dump_out = r_entries[PIPE_LAT-1].valid & r_entries[PIPE_LAT-1].is_dump;
    end

endmodule

// File: rtl/accum_scheduler.sv
// Front-end controller for a PIPE_LAT-cycle accumulating RAM: serialises requests,
// stalls same-address hazards and sweeps the whole table out on command.
module accum_scheduler
    import accum_sched_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [AW-1:0]    req_addr_in,
    input  logic [WIDTH-1:0] req_summand_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic             dump_start_in,
    output logic             dump_busy_out,
    output logic [AW-1:0]    ram_addr_out,
    output logic [WIDTH-1:0] ram_summand_out,
    output logic             ram_valid_out,
    input  logic [WIDTH-1:0] ram_sum_in,
    input  logic [AW-1:0]    ram_addr_ret_in,
    input  logic             ram_result_valid_in,
    output logic [WIDTH-1:0] dump_data_out,
    output logic [AW-1:0]    dump_addr_out,
    output logic             dump_valid_out,
    output logic             dump_last_out,
    output logic [31:0]      stall_count_out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [AW-1:0] r_sweep;
    logic [31:0]   r_stall_count;
    logic          w_hazard;
    logic          w_empty;
    logic          w_tail_is_dump;
    logic          w_ready;
    logic          w_issue_is_dump;
    logic          w_stall;
    logic          w_dump_valid;

    inflight_tracker #(
        .AW       (AW),
        .PIPE_LAT (PIPE_LAT)
    ) u_tracker (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .push_valid_in    (ram_valid_out),
        .push_addr_in     (ram_addr_out),
        .push_is_dump_in  (w_issue_is_dump),
        .cmp_addr_in      (req_addr_in),
        .hazard_out       (w_hazard),
        .empty_out        (w_empty),
        .tail_is_dump_out (w_tail_is_dump)
    );

    // Handshake and RAM issue mux: requests in ACCUM, sweep reads in DUMP_ISSUE.
    always_comb begin
        w_ready         = 1'b0;
        w_stall         = 1'b0;
        w_issue_is_dump = 1'b0;
        ram_valid_out   = 1'b0;
        ram_addr_out    = req_addr_in;
        ram_summand_out = req_summand_in;
        if (rst_in) begin
            ram_addr_out    = '0;
            ram_summand_out = '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    // A dump request closes the door in the same cycle it arrives.
                    w_ready       = ~(req_valid_in & w_hazard) & ~dump_start_in;
                    w_stall       = req_valid_in & w_hazard;
                    ram_valid_out = req_valid_in & w_ready;
                end
                DUMP_ISSUE: begin
                    ram_valid_out   = 1'b1;
                    ram_addr_out    = r_sweep;
                    ram_summand_out = '0;
                    w_issue_is_dump = 1'b1;
                end
                default: begin
                    w_ready = 1'b0;
                end
            endcase
        end
    end

    assign req_ready_out = w_ready;

    // Dump words are the RAM results whose tracker tail entry was a sweep read.
    always_comb begin
        w_dump_valid   = ~rst_in & ram_result_valid_in & w_tail_is_dump;
        dump_valid_out = w_dump_valid;
        dump_data_out  = w_dump_valid ? ram_sum_in : '0;
        dump_addr_out  = w_dump_valid ? ram_addr_ret_in : '0;
        dump_last_out  = w_dump_valid & (ram_addr_ret_in == LAST_ADDR);
        dump_busy_out  = ~rst_in & (r_state != ACCUM);
    end

    // Next-state logic for the accumulate / drain / sweep sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM: begin
                if (dump_start_in) w_state_nxt = DRAIN;
                else               w_state_nxt = ACCUM;
            end
            DRAIN: begin
                if (w_empty) w_state_nxt = DUMP_ISSUE;
                else         w_state_nxt = DRAIN;
            end
            DUMP_ISSUE: begin
                if (r_sweep == LAST_ADDR) w_state_nxt = DUMP_WAIT;
                else                      w_state_nxt = DUMP_ISSUE;
            end
            DUMP_WAIT: begin
                if (dump_last_out) w_state_nxt = ACCUM;
                else               w_state_nxt = DUMP_WAIT;
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    // Sweep address counter, rewound after the last bin is issued.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sweep <= '0;
        end else if (r_state == DUMP_ISSUE) begin
            r_sweep <= (r_sweep == LAST_ADDR) ? '0 : r_sweep + AW'(1);
        end else begin
            r_sweep <= r_sweep;
        end
    end

    // Saturating hazard-stall counter.
    always_ff @(posedge clk_in) begin
        if (rst_in)       r_stall_count <= 32'd0;
        else if (w_stall) r_stall_count <= sat_inc32(r_stall_count);
        else              r_stall_count <= r_stall_count;
    end

    assign stall_count_out = r_stall_count;

endmodule
